// File: rtl/prism_sp_config.sv
// Shared types and constants for the SP ACP transfer queue.
// acp_xfer_desc_t is sized by the ACP_* width constants below; the queue's
// width parameters default to the same values and must stay equal to them.
package prism_sp_config;

  localparam int ACP_LINE_BYTES  = 16;
  localparam int ACP_BURST_LINES = 4;

  localparam int ACP_ADDR_W   = 20;
  localparam int AXI_ADDR_W   = 40;
  localparam int ACP_NLINES_W = 16;
  localparam int ACP_TAG_W    = 3;

  typedef struct packed {
    logic                    write;
    logic [ACP_ADDR_W-1:0]   acpram_addr;
    logic [AXI_ADDR_W-1:0]   axi_addr;
    logic [ACP_NLINES_W-1:0] nlines;
    logic [ACP_TAG_W-1:0]    tag;
  } acp_xfer_desc_t;

  typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_ACK, S_WAIT} acp_xfer_state_t;

endpackage

// File: rtl/prism_sp_acp_desc_fifo.sv
// Descriptor FIFO for the ACP transfer queue.
//   push/push_data : enqueue (ignored when full or while flushing)
//   pop            : drop the head entry
//   flush          : empty the FIFO, pushes in the same cycle are dropped
//   flush_keep_head: keep only the head entry (unless popped this cycle)
//   head / count   : head entry and number of stored entries
module prism_sp_acp_desc_fifo
  import prism_sp_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  acp_xfer_desc_t         push_data,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   flush_keep_head,
  output acp_xfer_desc_t         head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  acp_xfer_desc_t mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           push_ok, pop_ok;

  always_comb begin
    push_ok  = push && !flush && !flush_keep_head && (count_q != (PW+1)'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    if (flush || (flush_keep_head && (pop_ok || count_q == '0))) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else if (flush_keep_head) begin
      wr_ptr_d = rd_ptr_q + PW'(1);
      count_d  = (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prism_sp_acp_xfer_queue.sv
// Descriptor queue and burst sequencer in front of the ACP RAM/AXI engine.
// Each queued descriptor is split into 4-beat (64 B) and 1-beat (16 B)
// engine commands; completion is reported with the descriptor tag.
//   enq_*  : descriptor input (valid/ready), abort drops queued work
//   eng_*  : engine start pulses, command address/length, engine busy
//   done_* : per-descriptor completion pulse and tag
//   count/active : queue occupancy (incl. in-progress head) and FSM status
module prism_sp_acp_xfer_queue
  import prism_sp_config::*;
#(
  parameter int QUEUE_DEPTH       = 4,
  parameter int ACPRAM_ADDR_WIDTH = ACP_ADDR_W,
  parameter int AXI_ADDR_WIDTH    = AXI_ADDR_W,
  parameter int NLINES_WIDTH      = ACP_NLINES_W,
  parameter int TAG_WIDTH         = ACP_TAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic                         enq_write,
  input  logic [ACPRAM_ADDR_WIDTH-1:0] enq_acpram_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]    enq_axi_addr,
  input  logic [NLINES_WIDTH-1:0]      enq_nlines,
  input  logic [TAG_WIDTH-1:0]         enq_tag,
  input  logic                         abort,
  output logic                         eng_read,
  output logic                         eng_write,
  output logic [ACPRAM_ADDR_WIDTH-1:0] eng_acpram_addr,
  output logic [AXI_ADDR_WIDTH-1:0]    eng_axi_addr,
  output logic                         eng_len,
  input  logic                         eng_busy,
  output logic                         done_valid,
  output logic [TAG_WIDTH-1:0]         done_tag,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic                         active
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  acp_xfer_state_t               state_q, state_d;
  logic                          dir_q, dir_d;
  logic [ACPRAM_ADDR_WIDTH-1:0]  laddr_q, laddr_d, eng_laddr_q, eng_laddr_d;
  logic [AXI_ADDR_WIDTH-1:0]     raddr_q, raddr_d, eng_raddr_q, eng_raddr_d;
  logic [NLINES_WIDTH-1:0]       rem_q, rem_d, rem_eff;
  logic [TAG_WIDTH-1:0]          tag_q, tag_d;
  logic                          burst_q, burst_d, eng_len_q, eng_len_d;
  logic                          issue, done, burst4;
  int                            step;
  acp_xfer_desc_t                enq_desc, head;

  assign enq_ready = (count < CW'(QUEUE_DEPTH));
  assign enq_desc  = '{write: enq_write, acpram_addr: enq_acpram_addr,
                       axi_addr: enq_axi_addr, nlines: enq_nlines, tag: enq_tag};

  prism_sp_acp_desc_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .push            (enq_valid && enq_ready),
    .push_data       (enq_desc),
    .pop             (done),
    .flush           (abort && state_q == S_IDLE),
    .flush_keep_head (abort && state_q != S_IDLE),
    .head            (head),
    .count           (count)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    laddr_d     = laddr_q;
    raddr_d     = raddr_q;
    rem_d       = rem_q;
    tag_d       = tag_q;
    burst_d     = burst_q;
    eng_laddr_d = eng_laddr_q;
    eng_raddr_d = eng_raddr_q;
    eng_len_d   = eng_len_q;
    issue       = 1'b0;
    done        = 1'b0;
    burst4      = 1'b0;
    step        = burst_q ? ACP_BURST_LINES : 1;
    // Abort collapses the rest of the descriptor; the head still completes.
    rem_eff     = abort ? '0 : rem_q;

    case (state_q)
      S_IDLE: begin
        if (!abort && count != '0) begin
          dir_d   = head.write;
          laddr_d = head.acpram_addr;
          raddr_d = head.axi_addr & ~AXI_ADDR_WIDTH'(ACP_LINE_BYTES - 1);
          rem_d   = head.nlines;
          tag_d   = head.tag;
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        if (rem_eff == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          issue       = 1'b1;
          burst4      = (rem_q >= NLINES_WIDTH'(ACP_BURST_LINES)) &&
                        (raddr_q[5:4] == 2'b00) && (laddr_q[1:0] == 2'b00);
          burst_d     = burst4;
          eng_laddr_d = laddr_q;
          eng_raddr_d = raddr_q;
          eng_len_d   = burst4;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        rem_d = rem_eff;
        if (eng_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        rem_d = rem_eff;
        if (!eng_busy) begin
          laddr_d = laddr_q + ACPRAM_ADDR_WIDTH'(step);
          raddr_d = raddr_q + AXI_ADDR_WIDTH'(step * ACP_LINE_BYTES);
          // Saturate so an abort-zeroed count does not wrap.
          rem_d   = (rem_eff < NLINES_WIDTH'(step)) ? '0 : rem_eff - NLINES_WIDTH'(step);
          state_d = S_SPLIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      laddr_q     <= '0;
      raddr_q     <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      burst_q     <= 1'b0;
      eng_laddr_q <= '0;
      eng_raddr_q <= '0;
      eng_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      laddr_q     <= laddr_d;
      raddr_q     <= raddr_d;
      rem_q       <= rem_d;
      tag_q       <= tag_d;
      burst_q     <= burst_d;
      eng_laddr_q <= eng_laddr_d;
      eng_raddr_q <= eng_raddr_d;
      eng_len_q   <= eng_len_d;
    end
  end

  // Command fields are live during the pulse and held afterwards.
  assign eng_read        = issue && !dir_q;
  assign eng_write       = issue && dir_q;
  assign eng_acpram_addr = issue ? laddr_q : eng_laddr_q;
  assign eng_axi_addr    = issue ? raddr_q : eng_raddr_q;
  assign eng_len         = issue ? burst4  : eng_len_q;
  assign done_valid      = done;
  assign done_tag        = done ? tag_q : '0;
  assign active          = (state_q != S_IDLE);

endmodule

// File: tb/tb_prism_sp_acp_xfer_queue.sv
module tb_prism_sp_acp_xfer_queue;

  typedef struct {
    bit          w;
    bit          len;
    logic [19:0] la;
    logic [39:0] ra;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst, enq_valid, enq_ready, enq_write, abort;
  logic [19:0] enq_acpram_addr, eng_acpram_addr;
  logic [39:0] enq_axi_addr, eng_axi_addr;
  logic [15:0] enq_nlines;
  logic [2:0]  enq_tag, done_tag;
  logic        eng_read, eng_write, eng_len, eng_busy, done_valid, active;
  logic [2:0]  count;

  int   total = 0, bad = 0;
  int   cyc = 0, enq_cyc = 0, done_cyc = 0;
  int   busy_len = 3, busy_left = 0;
  bit   stall = 0;
  cmd_t cmds[$];
  logic [2:0] dones[$];

  prism_sp_acp_xfer_queue dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_write(enq_write), .enq_acpram_addr(enq_acpram_addr),
    .enq_axi_addr(enq_axi_addr), .enq_nlines(enq_nlines), .enq_tag(enq_tag),
    .abort(abort), .eng_read(eng_read), .eng_write(eng_write),
    .eng_acpram_addr(eng_acpram_addr), .eng_axi_addr(eng_axi_addr),
    .eng_len(eng_len), .eng_busy(eng_busy), .done_valid(done_valid),
    .done_tag(done_tag), .count(count), .active(active)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: logs each start pulse, then holds busy for busy_len cycles.
  initial begin
    cmd_t c;
    eng_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_busy = 1'b0;
        busy_left = 0;
      end else if (eng_read || eng_write) begin
        c.w = eng_write; c.len = eng_len; c.la = eng_acpram_addr; c.ra = eng_axi_addr;
        cmds.push_back(c);
        eng_busy = 1'b1;
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        if (!stall) busy_left--;
        if (busy_left == 0) eng_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_valid) begin
      dones.push_back(done_tag);
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic enq_one(input bit w, input logic [19:0] la, input logic [39:0] ra,
                         input logic [15:0] n, input logic [2:0] t, output bit acc);
    @(negedge clk);
    enq_valid = 1'b1; enq_write = w; enq_acpram_addr = la;
    enq_axi_addr = ra; enq_nlines = n; enq_tag = t;
    acc = enq_ready;
    enq_cyc = cyc;
    @(posedge clk);
    #1 enq_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (count == 0 && !active && !eng_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    cmds.delete();
    dones.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({eng_read, eng_write, eng_len, done_valid, active, done_tag, count} !== 11'b0 ||
        eng_acpram_addr !== 20'h0 || eng_axi_addr !== 40'h0 || enq_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset got rd=%b wr=%b len=%b dv=%b act=%b tag=%0d cnt=%0d la=%h ra=%h rdy=%b exp all 0, rdy=1",
               eng_read, eng_write, eng_len, done_valid, active, done_tag, count,
               eng_acpram_addr, eng_axi_addr, enq_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_burst();
    bit acc, ok;
    bit          el[3] = '{1'b1, 1'b1, 1'b0};
    logic [19:0] ela[3] = '{20'd0, 20'd4, 20'd8};
    logic [39:0] era[3] = '{40'h1000, 40'h1040, 40'h1080};
    clear_logs();
    busy_len = 3;
    enq_one(1'b0, 20'd0, 40'h1000, 16'd9, 3'd5, acc);
    wait_idle(ok);
    total++;
    if (!ok || cmds.size() != 3) begin
      bad++;
      $display("FAIL read_cmd_count got %0d idle=%b exp 3 idle=1", cmds.size(), ok);
    end
    for (int i = 0; i < 3 && i < cmds.size(); i++) begin
      total++;
      if (cmds[i].w !== 1'b0 || cmds[i].len !== el[i] || cmds[i].la !== ela[i] || cmds[i].ra !== era[i]) begin
        bad++;
        $display("FAIL read_cmd%0d got w=%b len=%b la=%h ra=%h exp w=0 len=%b la=%h ra=%h",
                 i, cmds[i].w, cmds[i].len, cmds[i].la, cmds[i].ra, el[i], ela[i], era[i]);
      end
    end
    total++;
    if (dones.size() != 1 || dones[0] !== 3'd5) begin
      bad++;
      $display("FAIL read_done got n=%0d tag=%0d exp n=1 tag=5", dones.size(), dones[0]);
    end
  endtask

  task automatic test_write_burst();
    bit acc, ok;
    bit          el[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [19:0] ela[4] = '{20'd1, 20'd2, 20'd3, 20'd4};
    logic [39:0] era[4] = '{40'h2010, 40'h2020, 40'h2030, 40'h2040};
    clear_logs();
    enq_one(1'b1, 20'd1, 40'h2010, 16'd7, 3'd2, acc);
    wait_idle(ok);
    total++;
    if (!ok || cmds.size() != 4) begin
      bad++;
      $display("FAIL write_cmd_count got %0d idle=%b exp 4 idle=1", cmds.size(), ok);
    end
    for (int i = 0; i < 4 && i < cmds.size(); i++) begin
      total++;
      if (cmds[i].w !== 1'b1 || cmds[i].len !== el[i] || cmds[i].la !== ela[i] || cmds[i].ra !== era[i]) begin
        bad++;
        $display("FAIL write_cmd%0d got w=%b len=%b la=%h ra=%h exp w=1 len=%b la=%h ra=%h",
                 i, cmds[i].w, cmds[i].len, cmds[i].la, cmds[i].ra, el[i], ela[i], era[i]);
      end
    end
    total++;
    if (dones.size() != 1 || dones[0] !== 3'd2) begin
      bad++;
      $display("FAIL write_done got n=%0d tag=%0d exp n=1 tag=2", dones.size(), dones[0]);
    end
  endtask

  task automatic test_full();
    bit acc[5];
    bit ok;
    clear_logs();
    busy_len = 2;
    stall = 1'b1;
    for (int t = 0; t < 5; t++)
      enq_one(1'b0, 20'(t * 4), 40'(t * 256), 16'd1, 3'(t), acc[t]);
    @(negedge clk);
    total++;
    if (acc[0] !== 1'b1 || acc[1] !== 1'b1 || acc[2] !== 1'b1 || acc[3] !== 1'b1 ||
        acc[4] !== 1'b0 || enq_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got acc=%b%b%b%b%b rdy=%b exp 11110 rdy=0",
               acc[0], acc[1], acc[2], acc[3], acc[4], enq_ready);
    end
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL full_count got %0d exp 4", count);
    end
    stall = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok || dones.size() != 4 || dones[0] !== 3'd0 || dones[1] !== 3'd1 ||
        dones[2] !== 3'd2 || dones[3] !== 3'd3 || cmds.size() != 4) begin
      bad++;
      $display("FAIL full_order got n=%0d tags=%0d,%0d,%0d,%0d cmds=%0d exp n=4 tags=0,1,2,3 cmds=4",
               dones.size(), dones[0], dones[1], dones[2], dones[3], cmds.size());
    end
  endtask

  task automatic test_zero_len();
    bit acc, ok;
    clear_logs();
    enq_one(1'b0, 20'd3, 40'h500, 16'd0, 3'd7, acc);
    wait_idle(ok);
    total++;
    if (!ok || dones.size() != 1 || dones[0] !== 3'd7 || (done_cyc - enq_cyc) != 2) begin
      bad++;
      $display("FAIL zero_done got n=%0d tag=%0d lat=%0d exp n=1 tag=7 lat=2",
               dones.size(), dones[0], done_cyc - enq_cyc);
    end
    total++;
    if (cmds.size() != 0) begin
      bad++;
      $display("FAIL zero_nocmd got %0d cmds exp 0", cmds.size());
    end
  endtask

  task automatic test_wrap();
    bit acc, ok;
    clear_logs();
    // Low address nibble must be ignored.
    enq_one(1'b1, 20'hFFFFF, 40'hFF_FFFF_FFF7, 16'd2, 3'd3, acc);
    wait_idle(ok);
    total++;
    if (!ok || cmds.size() != 2 || cmds[0].len !== 1'b0 || cmds[0].la !== 20'hFFFFF ||
        cmds[0].ra !== 40'hFF_FFFF_FFF0 || cmds[1].len !== 1'b0 || cmds[1].la !== 20'h0 ||
        cmds[1].ra !== 40'h0 || dones.size() != 1) begin
      bad++;
      $display("FAIL wrap got n=%0d c0=%b/%h/%h c1=%b/%h/%h done=%0d exp n=2 c0=0/fffff/fffffffff0 c1=0/00000/0000000000 done=1",
               cmds.size(), cmds[0].len, cmds[0].la, cmds[0].ra,
               cmds[1].len, cmds[1].la, cmds[1].ra, dones.size());
    end
  endtask

  task automatic test_abort();
    bit acc, ok;
    clear_logs();
    busy_len = 3;
    enq_one(1'b0, 20'd0,  40'h000, 16'd8, 3'd1, acc);  // accepted cycle c
    enq_one(1'b0, 20'd16, 40'h400, 16'd8, 3'd2, acc);  // c+1: head loaded
    enq_one(1'b0, 20'd32, 40'h800, 16'd8, 3'd3, acc);  // c+2: first pulse
    @(negedge clk);                                    // c+3: S_ACK
    @(negedge clk);                                    // c+4: S_WAIT, busy high
    abort = 1'b1;
    enq_valid = 1'b1; enq_write = 1'b0; enq_acpram_addr = 20'd48;
    enq_axi_addr = 40'hC00; enq_nlines = 16'd4; enq_tag = 3'd6;
    @(posedge clk);
    #1 abort = 1'b0; enq_valid = 1'b0;
    @(negedge clk);
    total++;
    if (count !== 3'd1 || cmds.size() != 1 || active !== 1'b1) begin
      bad++;
      $display("FAIL abort_flush got cnt=%0d cmds=%0d act=%b exp cnt=1 cmds=1 act=1",
               count, cmds.size(), active);
    end
    wait_idle(ok);
    total++;
    if (!ok || dones.size() != 1 || dones[0] !== 3'd1 || cmds.size() != 1) begin
      bad++;
      $display("FAIL abort_done got idle=%b n=%0d tag=%0d cmds=%0d exp idle=1 n=1 tag=1 cmds=1",
               ok, dones.size(), dones[0], cmds.size());
    end
    repeat (4) @(negedge clk);
    total++;
    if (count !== 3'd0 || active !== 1'b0 || dones.size() != 1 || cmds.size() != 1) begin
      bad++;
      $display("FAIL abort_settle got cnt=%0d act=%b n=%0d cmds=%0d exp 0 0 1 1",
               count, active, dones.size(), cmds.size());
    end
  endtask

  task automatic test_rst_in_ack();
    bit acc, ok;
    clear_logs();
    busy_len = 3;
    enq_one(1'b0, 20'd8, 40'h3000, 16'd4, 3'd2, acc);
    @(negedge clk);                                    // S_IDLE, head loads
    @(negedge clk);                                    // S_SPLIT
    total++;
    if (eng_read !== 1'b1 || eng_len !== 1'b1 || eng_acpram_addr !== 20'd8) begin
      bad++;
      $display("FAIL rst_pulse got rd=%b len=%b la=%h exp rd=1 len=1 la=00008", eng_read, eng_len, eng_acpram_addr);
    end
    @(negedge clk);                                    // S_ACK
    total++;
    if (eng_read !== 1'b0 || eng_acpram_addr !== 20'd8 || eng_axi_addr !== 40'h3000 || eng_len !== 1'b1) begin
      bad++;
      $display("FAIL rst_hold got rd=%b la=%h ra=%h len=%b exp rd=0 la=00008 ra=0000003000 len=1",
               eng_read, eng_acpram_addr, eng_axi_addr, eng_len);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({eng_read, eng_write, eng_len, done_valid, active, done_tag, count} !== 11'b0 ||
        eng_acpram_addr !== 20'h0 || eng_axi_addr !== 40'h0) begin
      bad++;
      $display("FAIL rst_mid got rd=%b wr=%b len=%b dv=%b act=%b tag=%0d cnt=%0d la=%h ra=%h exp all 0",
               eng_read, eng_write, eng_len, done_valid, active, done_tag, count, eng_acpram_addr, eng_axi_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (dones.size() != 0) begin
      bad++;
      $display("FAIL rst_nodone got %0d completions exp 0", dones.size());
    end
    clear_logs();
    enq_one(1'b0, 20'd5, 40'h50, 16'd1, 3'd4, acc);
    wait_idle(ok);
    total++;
    if (!ok || cmds.size() != 1 || cmds[0].w !== 1'b0 || cmds[0].len !== 1'b0 ||
        cmds[0].la !== 20'd5 || cmds[0].ra !== 40'h50 || dones.size() != 1 || dones[0] !== 3'd4) begin
      bad++;
      $display("FAIL rst_after got n=%0d w=%b len=%b la=%h ra=%h done=%0d/%0d exp n=1 w=0 len=0 la=00005 ra=0000000050 done=1/4",
               cmds.size(), cmds[0].w, cmds[0].len, cmds[0].la, cmds[0].ra, dones.size(), dones[0]);
    end
  endtask

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_write = 1'b0; abort = 1'b0;
    enq_acpram_addr = '0; enq_axi_addr = '0; enq_nlines = '0; enq_tag = '0;
    test_reset();
    test_read_burst();
    test_write_burst();
    test_full();
    test_zero_len();
    test_wrap();
    test_abort();
    test_rst_in_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
